// File: rtl/cpu_debug_ctrl.sv
// rtl/cpu_debug_ctrl.sv - host-driven CPU debug sequencer: clock-enable gating, breakpoint, bus snapshot readout
module cpu_debug_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int BP_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        cpu_clk_en,
    output logic        cpu_rst,
    output logic        halted,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_rdata,
    input  logic [31:0] bus_wdata
);

    localparam int RCW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_STEP, S_RUN, S_BP_LOAD, S_SEND
    } state_t;

    state_t          state, next_state;
    logic [RCW-1:0]  rst_cnt;
    logic [31:0]     tmo_cnt;
    logic [1:0]      byte_idx;
    logic [31:0]     buffer;
    logic [31:0]     shadow;
    logic [31:0]     bp_addr;
    logic            bp_en;
    logic            first;
    logic            hit;

    // first suppresses the match on the opening RUN cycle so RUN can leave a breakpoint
    assign hit = (state == S_RUN) && bp_en && (bus_addr == bp_addr) && !first;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        8'h01:               next_state = S_RESET;
                        8'h02:               next_state = S_STEP;
                        8'h03, 8'h04, 8'h05: next_state = S_SEND;
                        8'h06:               next_state = S_RUN;
                        8'h08:               next_state = S_BP_LOAD;
                        default:             next_state = S_IDLE;
                    endcase
                end
            end
            S_RESET: begin
                if (rst_cnt == RCW'(RST_CYCLES - 1)) next_state = S_IDLE;
            end
            S_STEP:  next_state = S_IDLE;
            S_RUN: begin
                if (hit || (rx_valid && rx_data == 8'h07)) next_state = S_IDLE;
            end
            S_BP_LOAD: begin
                if (rx_valid) begin
                    if (byte_idx == 2'd3) next_state = S_IDLE;
                end else if (tmo_cnt == 32'(BP_TIMEOUT)) begin
                    next_state = S_IDLE;
                end
            end
            S_SEND: begin
                if (tx_ready && byte_idx == 2'd3) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt  <= '0;
            tmo_cnt  <= 32'd0;
            byte_idx <= 2'd0;
            buffer   <= 32'd0;
            shadow   <= 32'd0;
            bp_addr  <= 32'd0;
            bp_en    <= 1'b0;
            first    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rst_cnt  <= '0;
                    tmo_cnt  <= 32'd0;
                    byte_idx <= 2'd0;
                    first    <= 1'b1;
                    if (rx_valid) begin
                        case (rx_data)
                            8'h03:   buffer <= bus_addr;
                            8'h04:   buffer <= bus_rdata;
                            8'h05:   buffer <= bus_wdata;
                            8'h09:   bp_en  <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                S_RESET: rst_cnt <= rst_cnt + RCW'(1);
                S_RUN:   first   <= 1'b0;
                S_BP_LOAD: begin
                    if (rx_valid) begin
                        tmo_cnt  <= 32'd0;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: shadow[7:0]   <= rx_data;
                            2'd1: shadow[15:8]  <= rx_data;
                            2'd2: shadow[23:16] <= rx_data;
                            default: begin
                                shadow[31:24] <= rx_data;
                                bp_addr       <= {rx_data, shadow[23:0]};
                                bp_en         <= 1'b1;
                            end
                        endcase
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_SEND: begin
                    if (tx_ready) byte_idx <= byte_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_clk_en = (state == S_STEP) || (state == S_RESET) || ((state == S_RUN) && !hit);
        cpu_rst    = (state == S_RESET);
        halted     = (state == S_IDLE);
        tx_valid   = (state == S_SEND);
        tx_data    = 8'h00;
        if (state == S_SEND) begin
            case (byte_idx)
                2'd0:    tx_data = buffer[7:0];
                2'd1:    tx_data = buffer[15:8];
                2'd2:    tx_data = buffer[23:16];
                default: tx_data = buffer[31:24];
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// tb/tb_cpu_debug_ctrl.sv - vector table, directed corner sequences and randomized model check for cpu_debug_ctrl
module tb_cpu_debug_ctrl;

    localparam int RSTC = 4;
    localparam int BPT  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        cpu_clk_en;
    logic        cpu_rst;
    logic        halted;
    logic [31:0] bus_addr = 32'd0;
    logic [31:0] bus_rdata = 32'd0;
    logic [31:0] bus_wdata = 32'd0;

    cpu_debug_ctrl #(.RST_CYCLES(RSTC), .BP_TIMEOUT(BPT)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .cpu_clk_en(cpu_clk_en), .cpu_rst(cpu_rst), .halted(halted),
        .bus_addr(bus_addr), .bus_rdata(bus_rdata), .bus_wdata(bus_wdata)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic        rv;
        logic [7:0]  rd;
        logic        tr;
        logic [31:0] addr;
        logic        h;
        logic        en;
        logic        cr;
        logic        tv;
        logic [7:0]  td;
    } vec_t;

    vec_t tv[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic set_in(input logic v, input logic [7:0] d, input logic tr);
        rx_valid = v;
        rx_data  = d;
        tx_ready = tr;
        #1;
    endtask

    task automatic edge_clk();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
        return w[i*8 +: 8];
    endfunction

    task automatic send_check(input logic [7:0] cmd, input logic [31:0] val, input int stall);
        set_in(1'b1, cmd, 1'b0); edge_clk();
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < stall; s++) begin
                set_in(1'b0, 8'h00, 1'b0);
                chk("send_stall_valid", 32'(tx_valid), 32'd1);
                chk("send_stall_data", 32'(tx_data), 32'(byte_of(val, b)));
                edge_clk();
            end
            set_in(1'b0, 8'h00, 1'b1);
            chk("send_data", 32'(tx_data), 32'(byte_of(val, b)));
            chk("send_valid", 32'(tx_valid), 32'd1);
            edge_clk();
        end
        set_in(1'b0, 8'h00, 1'b0);
        chk("send_done_valid", 32'(tx_valid), 32'd0);
        chk("send_done_halted", 32'(halted), 32'd1);
        edge_clk();
    endtask

    task automatic load_bp(input logic [31:0] a);
        set_in(1'b1, 8'h08, 1'b0); edge_clk();
        for (int b = 0; b < 4; b++) begin
            set_in(1'b1, byte_of(a, b), 1'b0);
            chk("bp_load_busy", 32'(halted), 32'd0);
            edge_clk();
        end
        set_in(1'b0, 8'h00, 1'b0);
        chk("bp_load_done", 32'(halted), 32'd1);
        edge_clk();
    endtask

    // CPU model: bus_addr advances by 4 after every enabled cycle
    task automatic run_from(input logic [31:0] start, input int maxc,
                            output int stopped, output int cycles, output logic last_en);
        logic [31:0] nxt;
        bus_addr = start;
        stopped = 0; cycles = 0; last_en = 1'b0;
        set_in(1'b1, 8'h06, 1'b0); edge_clk();
        for (int k = 0; k < maxc; k++) begin
            set_in(1'b0, 8'h00, 1'b0);
            if (halted) begin
                stopped = 1;
                break;
            end
            cycles++;
            last_en = cpu_clk_en;
            nxt = cpu_clk_en ? bus_addr + 32'd4 : bus_addr;
            edge_clk();
            bus_addr = nxt;
        end
    endtask

    task automatic halt_run();
        set_in(1'b1, 8'h07, 1'b0);
        chk("halt_accept_en", 32'(cpu_clk_en), 32'd1);
        edge_clk();
        set_in(1'b0, 8'h00, 1'b0);
        chk("halt_after_halted", 32'(halted), 32'd1);
        chk("halt_after_en", 32'(cpu_clk_en), 32'd0);
        edge_clk();
    endtask

    // reference model state
    int          m_reset_left;
    bit          m_step, m_run, m_first, m_bp_loading, m_bp_en;
    logic [31:0] m_bp_addr;
    int          m_bp_wait;
    logic [7:0]  m_send_q[$];
    logic [7:0]  m_bp_q[$];

    task automatic model_clear();
        m_reset_left = 0; m_step = 0; m_run = 0; m_first = 0;
        m_bp_loading = 0; m_bp_en = 0; m_bp_addr = 32'd0; m_bp_wait = 0;
        m_send_q.delete(); m_bp_q.delete();
    endtask

    function automatic bit model_idle();
        return m_reset_left == 0 && !m_step && !m_run && !m_bp_loading && m_send_q.size() == 0;
    endfunction

    function automatic bit model_hit();
        return m_run && m_bp_en && (bus_addr == m_bp_addr) && !m_first;
    endfunction

    task automatic model_check();
        bit h = model_hit();
        chk("rand_halted", 32'(halted), 32'(model_idle()));
        chk("rand_cpu_rst", 32'(cpu_rst), 32'(m_reset_left > 0));
        chk("rand_clk_en", 32'(cpu_clk_en), 32'(m_reset_left > 0 || m_step || (m_run && !h)));
        chk("rand_tx_valid", 32'(tx_valid), 32'(m_send_q.size() > 0));
        if (m_send_q.size() > 0) chk("rand_tx_data", 32'(tx_data), 32'(m_send_q[0]));
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) m_send_q.push_back(byte_of(w, b));
    endtask

    task automatic model_step();
        bit h = model_hit();
        if (rst) begin
            model_clear();
        end else if (model_idle()) begin
            if (rx_valid) begin
                case (rx_data)
                    8'h01: m_reset_left = RSTC;
                    8'h02: m_step = 1;
                    8'h03: push_word(bus_addr);
                    8'h04: push_word(bus_rdata);
                    8'h05: push_word(bus_wdata);
                    8'h06: begin m_run = 1; m_first = 1; end
                    8'h08: begin m_bp_loading = 1; m_bp_q.delete(); m_bp_wait = 0; end
                    8'h09: m_bp_en = 0;
                    default: ;
                endcase
            end
        end else if (m_reset_left > 0) begin
            m_reset_left--;
        end else if (m_step) begin
            m_step = 0;
        end else if (m_run) begin
            if (h || (rx_valid && rx_data == 8'h07)) m_run = 0;
            m_first = 0;
        end else if (m_bp_loading) begin
            if (rx_valid) begin
                m_bp_q.push_back(rx_data);
                m_bp_wait = 0;
                if (m_bp_q.size() == 4) begin
                    m_bp_addr = {m_bp_q[3], m_bp_q[2], m_bp_q[1], m_bp_q[0]};
                    m_bp_en = 1;
                    m_bp_loading = 0;
                end
            end else if (m_bp_wait == BPT) begin
                m_bp_loading = 0;
            end else begin
                m_bp_wait++;
            end
        end else begin
            if (tx_ready) void'(m_send_q.pop_front());
        end
    endtask

    initial begin
        int stopped, cycles;
        logic last_en;

        tv[0]  = '{1'b1, 8'h01, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        for (int i = 1; i <= 4; i++)
            tv[i] = '{1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tv[5]  = '{1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[6]  = '{1'b1, 8'h02, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[7]  = '{1'b1, 8'h02, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tv[8]  = '{1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[9]  = '{1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[10] = '{1'b1, 8'h03, 1'b0, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[11] = '{1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h78};
        tv[12] = '{1'b0, 8'h00, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h78};
        tv[13] = '{1'b0, 8'h00, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h56};
        tv[14] = '{1'b0, 8'h00, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h34};
        tv[15] = '{1'b0, 8'h00, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12};
        tv[16] = '{1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

        rst = 1'b1;
        edge_clk(); edge_clk();
        rst = 1'b0;
        set_in(1'b0, 8'h00, 1'b0);
        chk("reset_halted", 32'(halted), 32'd1);
        chk("reset_clk_en", 32'(cpu_clk_en), 32'd0);
        chk("reset_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("reset_tx_valid", 32'(tx_valid), 32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'd0);
        edge_clk();

        foreach (tv[i]) begin
            bus_addr = tv[i].addr;
            set_in(tv[i].rv, tv[i].rd, tv[i].tr);
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(tv[i].h));
            chk($sformatf("vec%0d_clk_en", i), 32'(cpu_clk_en), 32'(tv[i].en));
            chk($sformatf("vec%0d_cpu_rst", i), 32'(cpu_rst), 32'(tv[i].cr));
            chk($sformatf("vec%0d_tx_valid", i), 32'(tx_valid), 32'(tv[i].tv));
            if (tv[i].tv) chk($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(tv[i].td));
            edge_clk();
        end

        bus_addr = 32'h12345678;
        send_check(8'h03, 32'h12345678, 3);
        bus_rdata = 32'hCAFEF00D;
        send_check(8'h04, 32'hCAFEF00D, 0);
        bus_wdata = 32'hA5C3961E;
        send_check(8'h05, 32'hA5C3961E, 1);

        load_bp(32'hDEADBEEF);
        run_from(32'hDEADBEE0, 12, stopped, cycles, last_en);
        chk("bp_misaligned_runs_on", 32'(stopped), 32'd0);
        chk("bp_misaligned_en", 32'(last_en), 32'd1);
        halt_run();

        load_bp(32'hDEADBEF0);
        run_from(32'hDEADBEE0, 20, stopped, cycles, last_en);
        chk("bp_hit_stopped", 32'(stopped), 32'd1);
        chk("bp_hit_addr", bus_addr, 32'hDEADBEF0);
        chk("bp_hit_cycles", 32'(cycles), 32'd5);
        chk("bp_hit_en_low", 32'(last_en), 32'd0);
        edge_clk();

        set_in(1'b1, 8'h06, 1'b0); edge_clk();
        set_in(1'b0, 8'h00, 1'b0);
        chk("bp_first_skip_en", 32'(cpu_clk_en), 32'd1);
        edge_clk();
        bus_addr = 32'hDEADBEF4;
        set_in(1'b0, 8'h00, 1'b0);
        chk("bp_past_halted", 32'(halted), 32'd0);
        chk("bp_past_en", 32'(cpu_clk_en), 32'd1);
        edge_clk();
        halt_run();

        bus_addr = 32'h00000100;
        set_in(1'b1, 8'h06, 1'b0); edge_clk();
        set_in(1'b1, 8'h01, 1'b0);
        chk("run_junk01_en", 32'(cpu_clk_en), 32'd1);
        edge_clk();
        set_in(1'b1, 8'h55, 1'b0);
        chk("run_junk55_en", 32'(cpu_clk_en), 32'd1);
        chk("run_junk_rst", 32'(cpu_rst), 32'd0);
        edge_clk();
        set_in(1'b1, 8'h08, 1'b0);
        chk("run_junk08_halted", 32'(halted), 32'd0);
        edge_clk();
        halt_run();
        set_in(1'b0, 8'h00, 1'b0);
        chk("halt_settled_rst", 32'(cpu_rst), 32'd0);
        chk("halt_settled_halted", 32'(halted), 32'd1);
        edge_clk();

        set_in(1'b1, 8'h09, 1'b0); edge_clk();
        set_in(1'b1, 8'h08, 1'b0); edge_clk();
        set_in(1'b1, 8'h11, 1'b0); edge_clk();
        for (int k = 1; k <= 20; k++) begin
            set_in(1'b0, 8'h00, 1'b0);
            if (k == 15) chk("tmo_still_loading", 32'(halted), 32'd0);
            if (k == 20) chk("tmo_back_idle", 32'(halted), 32'd1);
            edge_clk();
        end
        run_from(32'hDEADBEF0, 1, stopped, cycles, last_en);
        bus_addr = 32'hDEADBEF0;
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, 8'h00, 1'b0);
            chk("tmo_bp_disabled_en", 32'(cpu_clk_en), 32'd1);
            edge_clk();
            bus_addr = 32'hDEADBEF0;
        end
        halt_run();

        bus_addr = 32'h0BADF00D;
        set_in(1'b1, 8'h03, 1'b0); edge_clk();
        set_in(1'b0, 8'h00, 1'b1); edge_clk();
        set_in(1'b0, 8'h00, 1'b0);
        chk("midsend_valid", 32'(tx_valid), 32'd1);
        rst = 1'b1;
        edge_clk();
        rst = 1'b0;
        set_in(1'b0, 8'h00, 1'b0);
        chk("midsend_rst_valid", 32'(tx_valid), 32'd0);
        chk("midsend_rst_halted", 32'(halted), 32'd1);
        edge_clk();

        rst = 1'b1;
        model_clear();
        edge_clk();
        rst = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            logic       rv;
            logic [7:0] rd;
            int         k;
            rst = ($urandom_range(0, 149) == 0);
            rv = ($urandom_range(0, 2) == 0);
            k = $urandom_range(0, 10);
            rd = (k <= 9) ? 8'(k) : 8'($urandom);
            bus_addr  = $urandom_range(0, 1) ? m_bp_addr : $urandom;
            bus_rdata = $urandom;
            bus_wdata = $urandom;
            set_in(rv, rd, 1'($urandom_range(0, 1)));
            if (!rst) model_check();
            model_step();
            edge_clk();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
